// File: rtl/aes_pkg.sv
// Shared AES datapath types and the block-to-word helper used by the plaintext serializer.
package aes_pkg;

    typedef logic [127:0] block_t;
    typedef logic [31:0]  word_t;

    localparam int WORDS_PER_BLOCK = 4;
    localparam int WIDX_W          = $clog2(WORDS_PER_BLOCK);

    typedef enum logic {
        SER_IDLE,
        SER_STREAM
    } ser_state_t;

    // Word 0 is the most-significant 32 bits of the block.
    function automatic word_t block_word(input block_t blk, input logic [WIDX_W-1:0] idx);
        word_t w;
        case (idx)
            2'd0:    w = blk[127:96];
            2'd1:    w = blk[95:64];
            2'd2:    w = blk[63:32];
            default: w = blk[31:0];
        endcase
        return w;
    endfunction

endpackage

// File: rtl/aes_blk_fifo.sv
// Generic synchronous FIFO of DEPTH entries with occupancy output; a push is accepted
// when full only if a pop happens in the same cycle.
`ifndef DFF_ARN
`define DFF_ARN(q, d, rstval) always_ff @(posedge clk or negedge rst_b) if (!rst_b) q <= (rstval); else q <= (d);
`endif

module aes_blk_fifo
    import aes_pkg::*;
#(
    parameter int DEPTH = 8,
    parameter int CW = $clog2(DEPTH + 1),
    parameter type data_t = block_t
) (
    input  logic          clk,
    input  logic          rst_b,
    input  logic          push,
    input  logic          pop,
    input  data_t         wdata,
    output data_t         rdata,
    output logic          full,
    output logic          empty,
    output logic [CW-1:0] occ
);

    localparam int AW = $clog2(DEPTH);
    localparam int DW = $bits(data_t);

    logic [DEPTH-1:0][DW-1:0] mem;
    logic [DEPTH-1:0][DW-1:0] mem_d;
    logic [AW-1:0]            wptr;
    logic [AW-1:0]            wptr_d;
    logic [AW-1:0]            rptr;
    logic [AW-1:0]            rptr_d;
    logic [CW-1:0]            occ_d;
    logic                     do_push;
    logic                     do_pop;

    assign empty   = (occ == '0);
    assign full    = (occ == CW'(DEPTH));
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign rdata   = data_t'(mem[rptr]);

    // Pointers wrap naturally because DEPTH is a power of two.
    always_comb begin
        mem_d  = mem;
        wptr_d = wptr;
        rptr_d = rptr;
        occ_d  = occ;
        if (do_push) begin
            mem_d[wptr] = DW'(wdata);
            wptr_d      = wptr + AW'(1);
        end
        if (do_pop) begin
            rptr_d = rptr + AW'(1);
        end
        case ({do_push, do_pop})
            2'b10:   occ_d = occ + CW'(1);
            2'b01:   occ_d = occ - CW'(1);
            default: occ_d = occ;
        endcase
    end

    `DFF_ARN(mem, mem_d, '0)
    `DFF_ARN(wptr, wptr_d, '0)
    `DFF_ARN(rptr, rptr_d, '0)
    `DFF_ARN(occ, occ_d, '0)

endmodule

// File: rtl/aes_pt_serializer.sv
// Buffers 128-bit plaintext blocks from aes_decrypt and streams them as four 32-bit words,
// issuing load credit. Optional sticky protocol-error flag under AES_PT_SER_ERR_EN.
module aes_pt_serializer
    import aes_pkg::*;
#(
    parameter int DEPTH = 8,
    parameter int CW = $clog2(DEPTH + 1)
) (
    input  logic         clk,
    input  logic         rst_b,
    input  logic         load,
    input  logic         pt_valid,
    input  logic [127:0] pt,
    output logic         load_ok,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [31:0]  out_data,
    output logic         out_last,
    output logic         err
);

    localparam int                SUM_W    = CW + 1;
    localparam logic [WIDX_W-1:0] LAST_IDX = WIDX_W'(WORDS_PER_BLOCK - 1);

    ser_state_t        state_q;
    ser_state_t        state_d;
    block_t            head;
    logic              fifo_full;
    logic              fifo_empty;
    logic [CW-1:0]     occ;
    logic [CW-1:0]     inflight;
    logic [WIDX_W-1:0] word_idx;
    logic              xfer;
    logic              pop;
    logic              push;

    assign xfer = out_valid && out_ready;
    assign pop  = xfer && (word_idx == LAST_IDX);
    assign push = pt_valid && (!fifo_full || pop);

    aes_blk_fifo #(
        .DEPTH  (DEPTH),
        .CW     (CW),
        .data_t (block_t)
    ) u_fifo (
        .clk   (clk),
        .rst_b (rst_b),
        .push  (push),
        .pop   (pop),
        .wdata (pt),
        .rdata (head),
        .full  (fifo_full),
        .empty (fifo_empty),
        .occ   (occ)
    );

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            state_q <= SER_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // STREAM mirrors a non-empty FIFO; leave it only when the last entry pops with no refill.
    always_comb begin
        state_d = state_q;
        case (state_q)
            SER_IDLE: begin
                if (push) state_d = SER_STREAM;
            end
            SER_STREAM: begin
                if (pop && (occ == CW'(1)) && !push) state_d = SER_IDLE;
            end
            default: state_d = SER_IDLE;
        endcase
    end

    assign out_valid = (state_q == SER_STREAM);
    assign out_last  = out_valid && (word_idx == LAST_IDX);
    assign out_data  = out_valid ? block_word(head, word_idx) : '0;

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            word_idx <= '0;
        end else if (pop) begin
            word_idx <= '0;
        end else if (xfer) begin
            word_idx <= word_idx + WIDX_W'(1);
        end
    end

    // Blocks loaded but not yet delivered; saturating so a misbehaving source cannot wrap it.
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            inflight <= '0;
        end else if (load && !pt_valid && (inflight != '1)) begin
            inflight <= inflight + CW'(1);
        end else if (pt_valid && !load && (inflight != '0)) begin
            inflight <= inflight - CW'(1);
        end
    end

    assign load_ok = (({1'b0, occ} + {1'b0, inflight}) < SUM_W'(DEPTH));

`ifdef AES_PT_SER_ERR_EN
    logic drop;
    logic err_q;

    assign drop = pt_valid && fifo_full && !pop;

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            err_q <= 1'b0;
        end else if ((load && !load_ok) || drop || (pt_valid && (inflight == '0))) begin
            err_q <= 1'b1;
        end
    end

    assign err = err_q;

`ifndef SYNTHESIS
    always @(posedge clk) begin
        if (rst_b) begin
            assert (!(load && !load_ok)) else $error("aes_pt_serializer: load without credit");
            assert (!drop) else $error("aes_pt_serializer: plaintext block dropped, FIFO full");
            assert (!(pt_valid && (inflight == '0))) else $error("aes_pt_serializer: pt_valid with nothing in flight");
        end
    end
`endif
`else
    assign err = 1'b0;
`endif

endmodule
